seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the calculator's 4-digit common-anode seven-segment display.
- Shares the single segment/dp bus between DIGITS digit anodes using an internal slot counter, which acts as a clock-enable prescaler with no derived clock.
- Inserts a blanked guard interval between digits to suppress ghosting.
- Double-buffers display data so a new value is shown only from a frame boundary, which prevents tearing.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 17 +
 rtl/seg_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low, packed as {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bit position of each segment within a pattern
    localparam logic [2:0] SEG_A = 3'd0;
    localparam logic [2:0] SEG_B = 3'd1;
    localparam logic [2:0] SEG_C = 3'd2;
    localparam logic [2:0] SEG_D = 3'd3;
    localparam logic [2:0] SEG_E = 3'd4;
    localparam logic [2:0] SEG_F = 3'd5;
    localparam logic [2:0] SEG_G = 3'd6;

    localparam logic [6:0] HEX2SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_c_o
);

    logic [6:0] pat_c;

    assign pat_c = HEX2SEG[hex_i];

    // Reassembled from named positions so a board with a different segment wiring only edits the package
    assign seg_c_o = {pat_c[SEG_G], pat_c[SEG_F], pat_c[SEG_E], pat_c[SEG_D],
                      pat_c[SEG_C], pat_c[SEG_B], pat_c[SEG_A]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display with
// per-slot blanking guard and frame-aligned double-buffered display data.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned GUARD_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done,
    output logic                  applied
);

    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = 32;

    scan_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [VAL_W-1:0]   shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]  shadow_blank_q, shadow_blank_d;
    logic [DIGITS-1:0]  shadow_dp_q, shadow_dp_d;
    logic [VAL_W-1:0]   pend_val_q, pend_val_d;
    logic [DIGITS-1:0]  pend_blank_q, pend_blank_d;
    logic [DIGITS-1:0]  pend_dp_q, pend_dp_d;
    logic               pending_q, pending_d;

    logic [DIGITS-1:0]  an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               frame_done_q, frame_done_d;
    logic               applied_q, applied_d;

    logic               boundary_c;
    logic [3:0]         nib_c;
    logic [6:0]         dec_c;

    // Decoder sees next-state data so the registered segments align with the anodes
    assign nib_c = 4'(shadow_val_d >> {idx_d, 2'b00});

    seg7_decode u_dec (
        .hex_i   (nib_c),
        .seg_c_o (dec_c)
    );

    // Slot sequencing
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q + CNT_W'(1);
        boundary_c = 1'b0;
        case (state_q)
            GUARD: begin
                if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = GUARD;
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        idx_d      = '0;
                        boundary_c = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = GUARD;
            end
        endcase
    end

    // Pending buffer and shadow update; a load on the boundary edge bypasses the buffer
    always_comb begin
        shadow_val_d   = shadow_val_q;
        shadow_blank_d = shadow_blank_q;
        shadow_dp_d    = shadow_dp_q;
        pend_val_d     = pend_val_q;
        pend_blank_d   = pend_blank_q;
        pend_dp_d      = pend_dp_q;
        pending_d      = pending_q;
        applied_d      = 1'b0;
        frame_done_d   = boundary_c;
        if (boundary_c) begin
            if (load) begin
                shadow_val_d   = value;
                shadow_blank_d = blank_mask;
                shadow_dp_d    = dp_mask;
                pending_d      = 1'b0;
                applied_d      = 1'b1;
            end else if (pending_q) begin
                shadow_val_d   = pend_val_q;
                shadow_blank_d = pend_blank_q;
                shadow_dp_d    = pend_dp_q;
                pending_d      = 1'b0;
                applied_d      = 1'b1;
            end
        end else if (load) begin
            pend_val_d   = value;
            pend_blank_d = blank_mask;
            pend_dp_d    = dp_mask;
            pending_d    = 1'b1;
        end
    end

    // Display outputs from next state
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_d == DRIVE) begin
            if (!1'(shadow_blank_d >> idx_d)) begin
                an_d = ~(DIGITS'(1) << idx_d);
            end
            seg_d = dec_c;
            dp_d  = ~1'(shadow_dp_d >> idx_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= GUARD;
            idx_q          <= '0;
            cnt_q          <= '0;
            shadow_val_q   <= '0;
            shadow_blank_q <= '0;
            shadow_dp_q    <= '0;
            pend_val_q     <= '0;
            pend_blank_q   <= '0;
            pend_dp_q      <= '0;
            pending_q      <= 1'b0;
            an_q           <= '1;
            seg_q          <= SEG_BLANK;
            dp_q           <= 1'b1;
            frame_done_q   <= 1'b0;
            applied_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            shadow_val_q   <= shadow_val_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_dp_q    <= shadow_dp_d;
            pend_val_q     <= pend_val_d;
            pend_blank_q   <= pend_blank_d;
            pend_dp_q      <= pend_dp_d;
            pending_q      <= pending_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            frame_done_q   <= frame_done_d;
            applied_q      <= applied_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
    assign applied    = applied_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 10-cycle slot and 2-cycle guard.
// k counts active edges since the last reset release; outputs are sampled on the falling edge.
module tb_seg_scan_ctrl;

    localparam int unsigned DIGITS       = 4;
    localparam int unsigned SLOT_CYCLES  = 10;
    localparam int unsigned GUARD_CYCLES = 2;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        applied;

    int checks;
    int errors;
    int k;
    int applied_seen;

    seg_scan_ctrl #(
        .DIGITS       (DIGITS),
        .SLOT_CYCLES  (SLOT_CYCLES),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done),
        .applied    (applied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        k++;
        if (applied === 1'b1) applied_seen++;
    endtask

    task automatic advance_to(input int target);
        while (k < target) tick();
    endtask

    // Drive load for one cycle so it is sampled at edge k+1
    task automatic do_load(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] dm);
        load       = 1'b1;
        value      = v;
        blank_mask = bm;
        dp_mask    = dm;
        tick();
        load       = 1'b0;
    endtask

    task automatic check_disp(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp);
        check({tag, ".an"}, 32'(an), 32'(e_an));
        check({tag, ".seg"}, 32'(seg), 32'(e_seg));
        check({tag, ".dp"}, 32'(dp), 32'(e_dp));
    endtask

    initial begin
        int base;
        checks       = 0;
        errors       = 0;
        k            = 0;
        applied_seen = 0;
        rst          = 1'b0;
        load         = 1'b0;
        value        = '0;
        blank_mask   = '0;
        dp_mask      = '0;

        // Reset and scan
        repeat (3) @(negedge clk);
        check_disp("rst", 4'hF, 7'h7F, 1'b1);
        check("rst.frame_done", 32'(frame_done), 32'd0);
        check("rst.applied", 32'(applied), 32'd0);
        rst = 1'b1;
        k   = 0;
        advance_to(1);  check_disp("guard0", 4'hF, 7'h7F, 1'b1);
        advance_to(2);  check_disp("d0.first", 4'hE, 7'h40, 1'b1);
        advance_to(9);  check_disp("d0.last", 4'hE, 7'h40, 1'b1);
        advance_to(10); check_disp("guard1", 4'hF, 7'h7F, 1'b1);
        advance_to(12); check_disp("d1", 4'hD, 7'h40, 1'b1);
        advance_to(22); check_disp("d2", 4'hB, 7'h40, 1'b1);
        advance_to(32); check_disp("d3", 4'h7, 7'h40, 1'b1);
        advance_to(39); check("fd.before", 32'(frame_done), 32'd0);
        advance_to(40);
        check("fd.frame1", 32'(frame_done), 32'd1);
        check("ap.frame1", 32'(applied), 32'd0);
        check("guard.frame1", 32'(an), 32'hF);
        advance_to(41); check("fd.after", 32'(frame_done), 32'd0);

        // Mid-frame load becomes visible only after the next boundary
        advance_to(54);
        do_load(16'h1234, 4'b0000, 4'b0000);
        advance_to(62); check_disp("midload.old", 4'hB, 7'h40, 1'b1);
        applied_seen = 0;
        advance_to(80);
        check("ml.fd", 32'(frame_done), 32'd1);
        check("ml.applied", 32'(applied), 32'd1);
        advance_to(81); check("ml.applied.pulse", 32'(applied), 32'd0);
        advance_to(82);  check_disp("ml.d0", 4'hE, 7'h19, 1'b1);
        advance_to(92);  check_disp("ml.d1", 4'hD, 7'h30, 1'b1);
        advance_to(102); check_disp("ml.d2", 4'hB, 7'h24, 1'b1);
        advance_to(112); check_disp("ml.d3", 4'h7, 7'h79, 1'b1);
        check("ml.applied.count", 32'(applied_seen), 32'd1);

        // Blank digit 1, decimal point on digit 2
        advance_to(129);
        do_load(16'h1234, 4'b0010, 4'b0100);
        advance_to(160); check("bl.applied", 32'(applied), 32'd1);
        advance_to(162); check_disp("bl.d0", 4'hE, 7'h19, 1'b1);
        for (int c = 170; c < 180; c++) begin
            advance_to(c);
            check("bl.d1.an", 32'(an), 32'hF);
        end
        advance_to(181); check("bl.d2.guard.dp", 32'(dp), 32'd1);
        advance_to(182); check_disp("bl.d2", 4'hB, 7'h24, 1'b0);
        advance_to(189); check("bl.d2.last.dp", 32'(dp), 32'd0);
        advance_to(192); check_disp("bl.d3", 4'h7, 7'h79, 1'b1);

        // Pending 1111 overridden by a load on the boundary edge itself
        advance_to(209);
        do_load(16'h1111, 4'b0000, 4'b0000);
        advance_to(239);
        check("bp.pre.seg", 32'(seg), 32'h79);
        do_load(16'hFFFF, 4'b0000, 4'b0000);
        check("bp.fd", 32'(frame_done), 32'd1);
        check("bp.applied", 32'(applied), 32'd1);
        advance_to(242); check_disp("bp.d0", 4'hE, 7'h0E, 1'b1);
        advance_to(252); check_disp("bp.d1", 4'hD, 7'h0E, 1'b1);
        advance_to(272); check_disp("bp.d3", 4'h7, 7'h0E, 1'b1);
        advance_to(280);
        check("bp.next.fd", 32'(frame_done), 32'd1);
        check("bp.next.applied", 32'(applied), 32'd0);

        // Two loads in one frame coalesce into one applied pulse
        advance_to(289);
        do_load(16'hAAAA, 4'b0000, 4'b0000);
        advance_to(299);
        do_load(16'hBBBB, 4'b0000, 4'b0000);
        applied_seen = 0;
        advance_to(319); check("co.old.seg", 32'(seg), 32'h0E);
        advance_to(320); check("co.applied", 32'(applied), 32'd1);
        base = 322;
        for (int d = 0; d < 4; d++) begin
            advance_to(base + 10 * d);
            check("co.seg", 32'(seg), 32'h03);
        end
        advance_to(362);
        check("co.applied.count", 32'(applied_seen), 32'd1);

        // Asynchronous reset in the middle of digit 2's drive phase
        advance_to(385);
        check_disp("mr.pre", 4'hB, 7'h03, 1'b1);
        #1 rst = 1'b0;
        #1 check_disp("mr.async", 4'hF, 7'h7F, 1'b1);
        check("mr.fd", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        k   = 0;
        advance_to(1);  check_disp("mr.guard", 4'hF, 7'h7F, 1'b1);
        advance_to(2);  check_disp("mr.d0", 4'hE, 7'h40, 1'b1);
        advance_to(12); check_disp("mr.d1", 4'hD, 7'h40, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
